// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a one-hot registered enable, bounded hold time with
// preemption, and per-driver lock to keep the bus across multi-cycle transfers.
module bus_arbiter #(
  parameter int unsigned COUNT     = 8,
  parameter int unsigned MAX_HOLD  = 4,
  parameter int unsigned ID_WIDTH  = $clog2(COUNT + 1),
  parameter int unsigned CNT_WIDTH = $clog2(MAX_HOLD + 2)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [COUNT-1:0]    req,
  input  logic [COUNT-1:0]    lock,
  output logic [COUNT-1:0]    enable,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                busy,
  output logic                preempt
);

  localparam int unsigned PtrW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_WIDTH-1:0] MaxHoldC = CNT_WIDTH'(MAX_HOLD);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e               state_q;
  logic [COUNT-1:0]     enable_q;
  logic [ID_WIDTH-1:0]  grant_id_q;
  logic                 busy_q;
  logic                 preempt_q;
  logic [PtrW-1:0]      ptr_q;
  logic [PtrW-1:0]      owner_q;
  logic [CNT_WIDTH-1:0] hold_q;

  logic                 win_found;
  logic [PtrW-1:0]      win_idx;
  logic [PtrW-1:0]      next_ptr;
  logic                 owner_req;
  logic                 owner_lock;
  logic                 others_req;
  int unsigned          idx;

  // Cyclic search for the first requester starting at ptr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < COUNT; i++) begin
      idx = (int'(ptr_q) + i) % COUNT;
      if (!win_found && req[PtrW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = PtrW'(idx);
      end
    end
  end

  always_comb begin
    next_ptr   = PtrW'((int'(owner_q) + 1) % COUNT);
    owner_req  = req[owner_q];
    owner_lock = lock[owner_q];
    // enable_q is the owner's one-hot while in StOwn.
    others_req = |(req & ~enable_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      enable_q   <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
      ptr_q      <= '0;
      owner_q    <= '0;
      hold_q     <= '0;
    end else begin
      preempt_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            enable_q   <= COUNT'(1) << win_idx;
            grant_id_q <= ID_WIDTH'(int'(win_idx) + 1);
            busy_q     <= 1'b1;
            owner_q    <= win_idx;
            hold_q     <= CNT_WIDTH'(1);
            state_q    <= StOwn;
          end
        end
        StOwn: begin
          if (!owner_req) begin
            enable_q   <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= next_ptr;
            state_q    <= StIdle;
          end else if (MAX_HOLD != 0 && hold_q == MaxHoldC && !owner_lock && others_req) begin
            enable_q   <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b1;
            ptr_q      <= next_ptr;
            state_q    <= StIdle;
          end else if (hold_q < MaxHoldC) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign enable   = enable_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign preempt  = preempt_q;

endmodule
